dp_ram_arbiter: RTL and testbench

Round-robin arbiter that shares the two ports of the 32Kx4 dual-port RAM among `NREQ` requesters. Each cycle it grants up to two requests, one per RAM port, and drives the RAM port controls. It returns read data to the owning requester one cycle after grant. It sits between client engines and the RAM and is the only master of the RAM ports.

---
 rtl/dp_ram_pkg.sv | 16 +
 rtl/dp_ram_arbiter_rr_pick.sv | 36 +++
 rtl/dp_ram_arbiter.sv | 136 +++++++++++++
 tb/tb_dp_ram_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared constants and port bundle for the 32Kx4 dual-port RAM and its arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package dp_ram_pkg;

   localparam int DP_RAM_AW = 15;
   localparam int DP_RAM_DW = 4;

   // One RAM port's control bundle; both ports use the same layout.
   typedef struct packed {
      logic                 rw;
      logic [DP_RAM_AW-1:0] addr;
      logic [DP_RAM_DW-1:0] din;
   } dp_port_t;

endpackage

// File: rtl/dp_ram_arbiter_rr_pick.sv
// Circular first-one finder: the first set mask bit at or after start, wrapping.
// Latency: purely combinational.
// Backpressure: not applicable; the result is recomputed every cycle.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [IW:0]   sum;
   logic [IW-1:0] k;

   // Walk the N positions from start, keeping the first hit.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      sum   = '0;
      k     = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, start} + (IW+1)'(i);
         if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
         end
         k = sum[IW-1:0];
         if (!found && mask[k]) begin
            found = 1'b1;
            idx   = k;
         end
      end
   end

endmodule

// File: rtl/dp_ram_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto the dual-port RAM.
// Latency: grant is combinational; read data returns exactly one cycle after grant.
// Backpressure: requesters hold req until gnt; no stall on read return. Option: DP_ARB_COLLISION_CHECK_EN.
module dp_ram_arbiter
   import dp_ram_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int AW   = DP_RAM_AW,
   parameter int DW   = DP_RAM_DW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    we,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [NREQ*DW-1:0] rdata,
   output logic               ram_rw_1,
   output logic               ram_rw_2,
   output logic [AW-1:0]      ram_addr_1,
   output logic [AW-1:0]      ram_addr_2,
   output logic [DW-1:0]      ram_din_1,
   output logic [DW-1:0]      ram_din_2,
   input  logic [DW-1:0]      ram_dout_1,
   input  logic [DW-1:0]      ram_dout_2
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [AW-1:0]   req_addr  [NREQ];
   logic [DW-1:0]   req_wdata [NREQ];
   logic [DW-1:0]   rd_slice  [NREQ];
   logic [NREQ-1:0] p2_mask;
   logic [IW-1:0]   ptr, ptr_nxt, p1_idx, p2_idx, pend_idx_1, pend_idx_2;
   logic            p1_found, p2_found, pend_v_1, pend_v_2;
   dp_port_t        port_1, port_2;

   for (genvar k = 0; k < NREQ; k++) begin : g_slice
      assign req_addr[k]         = addr[k*AW +: AW];
      assign req_wdata[k]        = wdata[k*DW +: DW];
      assign rdata[k*DW +: DW]   = rd_slice[k];
   end

   rr_pick #(.N(NREQ), .IW(IW)) u_pick_1 (
      .mask(req), .start(ptr), .found(p1_found), .idx(p1_idx)
   );

   // Port 2 resumes the scan at the port-1 winner, which is masked out.
   rr_pick #(.N(NREQ), .IW(IW)) u_pick_2 (
      .mask(p2_mask), .start(p1_idx), .found(p2_found), .idx(p2_idx)
   );

`ifdef DP_ARB_COLLISION_CHECK_EN
   logic [NREQ-1:0] collide;
   for (genvar k = 0; k < NREQ; k++) begin : g_collide
      assign collide[k] = (req_addr[k] == req_addr[p1_idx]);
   end

   // Same-address candidates wait, so the RAM never sees a port collision.
   always_comb begin
      p2_mask         = req & ~collide;
      p2_mask[p1_idx] = 1'b0;
   end
`else
   // Any other requester may take port 2; same-address pairs follow RAM behaviour.
   always_comb begin
      p2_mask         = req;
      p2_mask[p1_idx] = 1'b0;
   end
`endif

   // Grants, port drive and pointer advance; everything idles while in reset.
   always_comb begin
      gnt     = '0;
      port_1  = '0;
      port_2  = '0;
      ptr_nxt = ptr;
      if (!rst && p1_found) begin
         gnt[p1_idx] = 1'b1;
         port_1.rw   = we[p1_idx];
         port_1.addr = req_addr[p1_idx];
         port_1.din  = req_wdata[p1_idx];
         ptr_nxt     = (p1_idx == IW'(NREQ-1)) ? '0 : p1_idx + 1'b1;
         if (p2_found) begin
            gnt[p2_idx] = 1'b1;
            port_2.rw   = we[p2_idx];
            port_2.addr = req_addr[p2_idx];
            port_2.din  = req_wdata[p2_idx];
            ptr_nxt     = (p2_idx == IW'(NREQ-1)) ? '0 : p2_idx + 1'b1;
         end
      end
   end

   assign ram_rw_1   = port_1.rw;
   assign ram_addr_1 = port_1.addr;
   assign ram_din_1  = port_1.din;
   assign ram_rw_2   = port_2.rw;
   assign ram_addr_2 = port_2.addr;
   assign ram_din_2  = port_2.din;

   // Pointer and one pending-read slot per port, reloaded every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr        <= '0;
         pend_v_1   <= 1'b0;
         pend_idx_1 <= '0;
         pend_v_2   <= 1'b0;
         pend_idx_2 <= '0;
      end else begin
         ptr        <= ptr_nxt;
         pend_v_1   <= p1_found && !we[p1_idx];
         pend_idx_1 <= p1_idx;
         pend_v_2   <= p1_found && p2_found && !we[p2_idx];
         pend_idx_2 <= p2_idx;
      end
   end

   // Route each port's RAM output back to the requester that issued the read.
   always_comb begin
      rvalid   = '0;
      rd_slice = '{default: '0};
      if (!rst) begin
         if (pend_v_1) begin
            rvalid[pend_idx_1]   = 1'b1;
            rd_slice[pend_idx_1] = ram_dout_1;
         end
         if (pend_v_2) begin
            rvalid[pend_idx_2]   = 1'b1;
            rd_slice[pend_idx_2] = ram_dout_2;
         end
      end
   end

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Directed bench for dp_ram_arbiter with a behavioural 32Kx4 dual-port RAM model.
// Latency: expects combinational grants and read return one cycle after grant.
// Backpressure: requests are held by the bench until it checks the grant. Option: DP_ARB_COLLISION_CHECK_EN.
module tb_dp_ram_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 15;
   localparam int DW   = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req, we, gnt, rvalid;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata, rdata;
   logic               ram_rw_1, ram_rw_2;
   logic [AW-1:0]      ram_addr_1, ram_addr_2, aq1, aq2;
   logic [DW-1:0]      ram_din_1, ram_din_2, ram_dout_1, ram_dout_2;
   logic [DW-1:0]      mem [0:(1<<AW)-1];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dp_ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .ram_rw_1(ram_rw_1), .ram_rw_2(ram_rw_2),
      .ram_addr_1(ram_addr_1), .ram_addr_2(ram_addr_2),
      .ram_din_1(ram_din_1), .ram_din_2(ram_din_2),
      .ram_dout_1(ram_dout_1), .ram_dout_2(ram_dout_2)
   );

   // RAM model: registered address, asynchronous read, port-1 write wins.
   always @(posedge clk) begin
      if (ram_rw_1) mem[ram_addr_1] <= ram_din_1;
      if (ram_rw_2 && !(ram_rw_1 && ram_addr_1 == ram_addr_2)) mem[ram_addr_2] <= ram_din_2;
      aq1 <= ram_addr_1;
      aq2 <= ram_addr_2;
   end
   assign ram_dout_1 = mem[aq1];
   assign ram_dout_2 = mem[aq2];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[k]             = 1'b1;
      we[k]              = w;
      addr[k*AW +: AW]   = a;
      wdata[k*DW +: DW]  = d;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req = '0; we = '0; addr = '0; wdata = '0;
      set_req(0, 1'b0, 15'h0001, 4'h0);
      set_req(1, 1'b0, 15'h0002, 4'h0);
      set_req(2, 1'b0, 15'h0003, 4'h0);
      set_req(3, 1'b0, 15'h0004, 4'h0);
      tick;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      checks++; if (rvalid !== 4'b0000 || rdata !== 16'h0) begin errors++; $display("FAIL reset_rvalid: got %b/%h want 0000/0000", rvalid, rdata); end
      tick;
      checks++; if ({ram_rw_1, ram_rw_2, ram_addr_1, ram_addr_2, ram_din_1, ram_din_2} !== '0) begin
         errors++; $display("FAIL reset_ram: rw %b%b addr %h %h din %h %h want all 0", ram_rw_1, ram_rw_2, ram_addr_1, ram_addr_2, ram_din_1, ram_din_2); end
      rst = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0011) begin errors++; $display("FAIL reset_first_gnt: got %b want 0011", gnt); end
      checks++; if (ram_addr_1 !== 15'h0001 || ram_addr_2 !== 15'h0002) begin
         errors++; $display("FAIL reset_first_addr: got %h %h want 0001 0002", ram_addr_1, ram_addr_2); end
      req = '0;
      tick;
   endtask

   task automatic test_writes_then_reads;
      set_req(0, 1'b1, 15'h0010, 4'hA);
      set_req(2, 1'b1, 15'h7FFF, 4'h5);
      #1;
      checks++; if (gnt !== 4'b0101) begin errors++; $display("FAIL wr_gnt: got %b want 0101", gnt); end
      checks++; if ({ram_rw_1, ram_addr_1, ram_din_1} !== {1'b1, 15'h0010, 4'hA}) begin
         errors++; $display("FAIL wr_port1: got rw %b addr %h din %h want 1 0010 a", ram_rw_1, ram_addr_1, ram_din_1); end
      checks++; if ({ram_rw_2, ram_addr_2, ram_din_2} !== {1'b1, 15'h7FFF, 4'h5}) begin
         errors++; $display("FAIL wr_port2: got rw %b addr %h din %h want 1 7fff 5", ram_rw_2, ram_addr_2, ram_din_2); end
      tick;
      req = '0;
      set_req(0, 1'b0, 15'h0010, 4'h0);
      set_req(2, 1'b0, 15'h7FFF, 4'h0);
      #1;
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL wr_no_resp: got %b want 0000", rvalid); end
      checks++; if (gnt !== 4'b0101 || ram_rw_1 !== 1'b0) begin errors++; $display("FAIL rd_gnt: got %b rw %b want 0101 0", gnt, ram_rw_1); end
      tick;
      req = '0;
      #1;
      checks++; if (rvalid !== 4'b0101) begin errors++; $display("FAIL rd_rvalid: got %b want 0101", rvalid); end
      checks++; if (rdata !== 16'h050A) begin errors++; $display("FAIL rd_rdata: got %h want 050a", rdata); end
      tick;
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL rd_pulse: got %b want 0000", rvalid); end
   endtask

   task automatic test_wrap;
      set_req(3, 1'b0, 15'h0123, 4'h0);
      set_req(0, 1'b0, 15'h0010, 4'h0);
      #1;
      checks++; if (gnt !== 4'b1001) begin errors++; $display("FAIL wrap_gnt: got %b want 1001", gnt); end
      checks++; if (ram_addr_1 !== 15'h0123 || ram_addr_2 !== 15'h0010) begin
         errors++; $display("FAIL wrap_ports: got %h %h want 0123 0010", ram_addr_1, ram_addr_2); end
      tick;
      req = '0;
      #1;
      checks++; if (rvalid !== 4'b1001 || rdata !== 16'h000A) begin
         errors++; $display("FAIL wrap_return: got %b/%h want 1001/000a", rvalid, rdata); end
   endtask

   task automatic test_collision;
      set_req(1, 1'b0, 15'h0100, 4'h0);
      set_req(2, 1'b1, 15'h0100, 4'h7);
      #1;
`ifdef DP_ARB_COLLISION_CHECK_EN
      checks++; if (gnt !== 4'b0010 || ram_rw_2 !== 1'b0) begin errors++; $display("FAIL coll_gnt: got %b rw2 %b want 0010 0", gnt, ram_rw_2); end
      tick;
      req[1] = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0100 || ram_rw_1 !== 1'b1) begin errors++; $display("FAIL coll_retry: got %b rw1 %b want 0100 1", gnt, ram_rw_1); end
`else
      checks++; if (gnt !== 4'b0110 || ram_rw_2 !== 1'b1) begin errors++; $display("FAIL coll_gnt: got %b rw2 %b want 0110 1", gnt, ram_rw_2); end
      tick;
      req = '0;
      #1;
`endif
      checks++; if (rvalid !== 4'b0010) begin errors++; $display("FAIL coll_rvalid: got %b want 0010", rvalid); end
      tick;
      req = '0;
   endtask

   task automatic test_rotation;
      set_req(3, 1'b0, 15'h0333, 4'h0);
      #1;
      checks++; if (gnt !== 4'b1000 || ram_rw_2 !== 1'b0 || ram_addr_2 !== 15'h0) begin
         errors++; $display("FAIL single_port1: got %b rw2 %b addr2 %h want 1000 0 0000", gnt, ram_rw_2, ram_addr_2); end
      tick;
      set_req(0, 1'b0, 15'h0010, 4'h0);
      set_req(1, 1'b0, 15'h0111, 4'h0);
      set_req(2, 1'b0, 15'h0222, 4'h0);
      #1;
      checks++; if (gnt !== 4'b0011 || rvalid !== 4'b1000) begin errors++; $display("FAIL rot_0: got %b/%b want 0011/1000", gnt, rvalid); end
      tick;
      checks++; if (gnt !== 4'b1100 || rvalid !== 4'b0011) begin errors++; $display("FAIL rot_1: got %b/%b want 1100/0011", gnt, rvalid); end
      checks++; if (rdata !== 16'h000A) begin errors++; $display("FAIL rot_1_data: got %h want 000a", rdata); end
      tick;
      checks++; if (gnt !== 4'b0011 || rvalid !== 4'b1100) begin errors++; $display("FAIL rot_2: got %b/%b want 0011/1100", gnt, rvalid); end
      tick;
      req = '0;
      #1;
      checks++; if (rvalid !== 4'b0011 || rdata !== 16'h000A) begin errors++; $display("FAIL rot_3: got %b/%h want 0011/000a", rvalid, rdata); end
   endtask

   task automatic test_back_to_back;
      set_req(0, 1'b0, 15'h0010, 4'h0);
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL b2b_gnt0: got %b want 0001", gnt); end
      tick;
      checks++; if (gnt !== 4'b0001 || rvalid !== 4'b0001 || rdata !== 16'h000A) begin
         errors++; $display("FAIL b2b_overlap: got %b/%b/%h want 0001/0001/000a", gnt, rvalid, rdata); end
      tick;
      req = '0;
      #1;
      checks++; if (rvalid !== 4'b0001 || rdata !== 16'h000A) begin errors++; $display("FAIL b2b_second: got %b/%h want 0001/000a", rvalid, rdata); end
      tick;
      checks++; if (rvalid !== 4'b0000 || rdata !== 16'h0) begin errors++; $display("FAIL b2b_done: got %b/%h want 0000/0000", rvalid, rdata); end
   endtask

   task automatic test_idle_hold;
      tick;
      tick;
      checks++; if (gnt !== 4'b0000 || ram_rw_1 !== 1'b0 || ram_addr_1 !== 15'h0) begin
         errors++; $display("FAIL idle_ports: got %b rw1 %b addr1 %h want 0000 0 0000", gnt, ram_rw_1, ram_addr_1); end
      req = 4'b1111; we = '0;
      #1;
      checks++; if (gnt !== 4'b0110) begin errors++; $display("FAIL idle_ptr_hold: got %b want 0110", gnt); end
      req = '0;
      #1;
   endtask

   task automatic test_reset_mid_read;
      set_req(2, 1'b0, 15'h7FFF, 4'h0);
      #1;
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mid_gnt: got %b want 0100", gnt); end
      tick;
      rst = 1'b1;
      req = '0;
      #1;
      checks++; if (rvalid !== 4'b0000 || rdata !== 16'h0) begin errors++; $display("FAIL mid_suppress: got %b/%h want 0000/0000", rvalid, rdata); end
      tick;
      rst = 1'b0;
      #1;
      checks++; if (rvalid !== 4'b0000 || gnt !== 4'b0000) begin errors++; $display("FAIL mid_empty: got %b/%b want 0000/0000", rvalid, gnt); end
      req = 4'b1111;
      #1;
      checks++; if (gnt !== 4'b0011) begin errors++; $display("FAIL mid_ptr_zero: got %b want 0011", gnt); end
      req = '0;
      tick;
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL mid_after: got %b want 0000", rvalid); end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      test_reset;
      test_writes_then_reads;
      test_wrap;
      test_collision;
      test_rotation;
      test_back_to_back;
      test_idle_hold;
      test_reset_mid_read;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
